// File: rtl/stage_cascade_controller.sv
// Cascade sequencer for one integral window: fetches each stage's size and threshold,
// triggers the stage classifier, accumulates its results and decides pass/fail per stage.
module stage_cascade_controller #(
  parameter int DATA_WIDTH_12     = 12,
  parameter int DATA_WIDTH_16     = 16,
  parameter int NUM_STAGE         = 25,
  parameter int STAGE_INDEX_WIDTH = 5
) (
  input  logic                            clk_fpga,
  input  logic                            reset_fpga,
  input  logic                            i_window_valid,
  output logic                            o_window_ready,
  output logic [STAGE_INDEX_WIDTH-1:0]    o_stage_index,
  input  logic [DATA_WIDTH_12-1:0]        i_stage_size,
  input  logic signed [DATA_WIDTH_16-1:0] i_stage_threshold,
  output logic                            o_trigger_compare_stage,
  input  logic                            i_haar_valid,
  input  logic signed [DATA_WIDTH_16-1:0] i_haar_value,
  input  logic                            i_is_end_of_stage,
  output logic                            o_candidate_valid,
  output logic                            o_is_candidate,
  output logic                            o_protocol_error
);

  localparam int ACC_W = DATA_WIDTH_16 + 8;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [STAGE_INDEX_WIDTH-1:0] LAST_INDEX = STAGE_INDEX_WIDTH'(NUM_STAGE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_TRIGGER, S_ACCUM, S_DECIDE, S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [STAGE_INDEX_WIDTH-1:0]   index_q, index_d;
  logic [DATA_WIDTH_12-1:0]       size_q, size_d;
  logic [DATA_WIDTH_12-1:0]       count_q, count_d;
  logic signed [DATA_WIDTH_16-1:0] thr_q, thr_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic                           ready_q, ready_d;
  logic                           trig_q, trig_d;
  logic                           cand_valid_q, cand_valid_d;
  logic                           is_cand_q, is_cand_d;
  logic                           err_q, err_d;

  logic signed [ACC_W:0]          acc_ext, haar_ext, sum;
  logic signed [ACC_W-1:0]        acc_sat, thr_ext;
  logic [DATA_WIDTH_12:0]         count_inc;
  logic                           last_result;
  logic                           stage_pass;

  always_comb begin
    acc_ext  = (ACC_W+1)'(acc_q);
    haar_ext = (ACC_W+1)'(i_haar_value);
    sum      = acc_ext + haar_ext;
    // A carry into the guard bit that disagrees with the sign bit means overflow.
    if (sum[ACC_W] != sum[ACC_W-1]) acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else                            acc_sat = sum[ACC_W-1:0];
    count_inc   = (DATA_WIDTH_12+1)'(count_q) + (DATA_WIDTH_12+1)'(1);
    last_result = (count_inc == (DATA_WIDTH_12+1)'(size_q));
    thr_ext     = ACC_W'(thr_q);
    stage_pass  = (acc_q >= thr_ext);
  end

  always_comb begin
    // NOTE: every *_d gets a default first so no path through the case can infer a latch.
    state_d   = state_q;
    index_d   = index_q;
    size_d    = size_q;
    thr_d     = thr_q;
    acc_d     = acc_q;
    count_d   = count_q;
    is_cand_d = is_cand_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (i_window_valid) begin
        state_d = S_FETCH;
        index_d = '0;
        acc_d   = '0;
        count_d = '0;
      end
      S_FETCH: begin
        size_d  = i_stage_size;
        thr_d   = i_stage_threshold;
        state_d = S_TRIGGER;
      end
      S_TRIGGER: state_d = (size_q == '0) ? S_DECIDE : S_ACCUM;
      S_ACCUM: if (i_haar_valid) begin
        acc_d   = acc_sat;
        count_d = count_inc[DATA_WIDTH_12-1:0];
        if (i_is_end_of_stage != last_result) err_d = 1'b1;
        if (last_result) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (!stage_pass) begin
          is_cand_d = 1'b0;
          state_d   = S_DONE;
        end else if (index_q == LAST_INDEX) begin
          is_cand_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          index_d = index_q + STAGE_INDEX_WIDTH'(1);
          acc_d   = '0;
          count_d = '0;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    ready_d      = (state_d == S_IDLE);
    trig_d       = (state_d == S_TRIGGER);
    cand_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_fpga) begin
    // NOTE: synchronous reset; the datapath registers are plain flops, so they are cleared too.
    if (!reset_fpga) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      size_q       <= '0;
      thr_q        <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      ready_q      <= 1'b1;
      trig_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      is_cand_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      size_q       <= size_d;
      thr_q        <= thr_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      trig_q       <= trig_d;
      cand_valid_q <= cand_valid_d;
      is_cand_q    <= is_cand_d;
      err_q        <= err_d;
    end
  end

  assign o_window_ready          = ready_q;
  assign o_stage_index           = index_q;
  assign o_trigger_compare_stage = trig_q;
  assign o_candidate_valid       = cand_valid_q;
  assign o_is_candidate          = is_cand_q;
  assign o_protocol_error        = err_q;

endmodule

// File: tb/tb_stage_cascade_controller.sv
// Bench for stage_cascade_controller: a one-stage and a three-stage instance, a scheduled
// timeline model built from stage tables, and a per-cycle compare against that timeline.
module tb_stage_cascade_controller;

  localparam int MAXT = 1024;
  localparam int NV   = 300;

  logic clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  logic              reset_fpga, win1, win3, hv, hflag;
  logic signed [15:0] hval;
  logic              rdy1, rdy3, trig1, trig3, cv1, cv3, cand1, cand3, err1, err3;
  logic [4:0]        idx1, idx3;
  logic [11:0]       size1, size3;
  logic signed [15:0] thr1, thr3;

  int cfg_size[3];
  int cfg_thr[3];
  int cfg_fpos[3];
  int cfg_vals[3][NV];

  always_comb begin
    size1 = '0; thr1 = '0; size3 = '0; thr3 = '0;
    if (idx1 < 5'd3) begin size1 = 12'(cfg_size[idx1]); thr1 = 16'(cfg_thr[idx1]); end
    if (idx3 < 5'd3) begin size3 = 12'(cfg_size[idx3]); thr3 = 16'(cfg_thr[idx3]); end
  end

  stage_cascade_controller #(.NUM_STAGE(1)) u_dut1 (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
    .i_window_valid(win1), .o_window_ready(rdy1), .o_stage_index(idx1),
    .i_stage_size(size1), .i_stage_threshold(thr1), .o_trigger_compare_stage(trig1),
    .i_haar_valid(hv), .i_haar_value(hval), .i_is_end_of_stage(hflag),
    .o_candidate_valid(cv1), .o_is_candidate(cand1), .o_protocol_error(err1)
  );

  stage_cascade_controller #(.NUM_STAGE(3)) u_dut3 (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
    .i_window_valid(win3), .o_window_ready(rdy3), .o_stage_index(idx3),
    .i_stage_size(size3), .i_stage_threshold(thr3), .o_trigger_compare_stage(trig3),
    .i_haar_valid(hv), .i_haar_value(hval), .i_is_end_of_stage(hflag),
    .o_candidate_valid(cv3), .o_is_candidate(cand3), .o_protocol_error(err3)
  );

  // Outputs of the instance under test and of the one that must stay idle.
  logic use1;
  logic a_rdy, a_trig, a_cv, a_cand, a_err, o_rdy, o_trig, o_cv;
  logic [4:0] a_idx;
  always_comb begin
    a_rdy  = use1 ? rdy1  : rdy3;   a_trig = use1 ? trig1 : trig3;
    a_cv   = use1 ? cv1   : cv3;    a_cand = use1 ? cand1 : cand3;
    a_err  = use1 ? err1  : err3;   a_idx  = use1 ? idx1  : idx3;
    o_rdy  = use1 ? rdy3  : rdy1;   o_trig = use1 ? trig3 : trig1;
    o_cv   = use1 ? cv3   : cv1;
  end

  // Stimulus schedule and expected timeline, indexed by cycle within a window.
  bit d_win[MAXT], d_hv[MAXT], d_flag[MAXT], d_rst[MAXT];
  int d_val[MAXT];
  int e_rdy[MAXT], e_trig[MAXT], e_cv[MAXT], e_cand[MAXT], e_err[MAXT], e_idx[MAXT];
  int x_rdy, x_trig, x_cv, x_cand, x_err, x_idx;

  // Per-instance held results carried between windows (index 1 = one-stage instance).
  int m_cand[2], m_err[2], m_idx[2];
  int m_cv, m_ntrig, m_len, m_errf;
  longint m_last_acc;

  int n_checks = 0, n_fail = 0, obs_trig = 0, obs_cv = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat24(input longint v);
    if (v > 8388607)  return 64'sd8388607;
    if (v < -8388608) return -64'sd8388608;
    return v;
  endfunction

  task automatic set_stage(input int s, input int size, input int thr, input int fill, input int fpos);
    cfg_size[s] = size;
    cfg_thr[s]  = thr;
    cfg_fpos[s] = (fpos < 0) ? size - 1 : fpos;
    for (int j = 0; j < NV; j++) cfg_vals[s][j] = fill;
  endtask

  task automatic cfg_three_pass();
    set_stage(0, 3, 6, 2, -1);
    set_stage(1, 1, -5, -5, -1);
    set_stage(2, 2, 99, 100, -1);
    cfg_vals[2][1] = -1;
  endtask

  // Schedules one window: accept at cycle 0, first trigger at 2, results right after each
  // trigger, decision one cycle after the last result, next stage trigger two cycles later.
  task automatic build_window(input bit sel1, input bit junk, input bit gaps, input int abort_at);
    int k, nstage, t, tt, last, s, cv, errf, newcand;
    longint acc;
    bit fin;
    k = sel1 ? 1 : 0;
    nstage = sel1 ? 1 : 3;
    for (int i = 0; i < MAXT; i++) begin
      d_win[i] = 0; d_hv[i] = 0; d_flag[i] = 0; d_rst[i] = 1; d_val[i] = 0;
      e_trig[i] = 0; e_idx[i] = m_idx[k];
    end
    d_win[0] = 1;
    if (junk) begin d_win[1] = 1; d_win[2] = 1; end
    errf = MAXT; s = 0; tt = 2; fin = 0; cv = 0; newcand = 0; acc = 0;
    while (!fin) begin
      e_trig[tt] = 1;
      for (int i = tt - 1; i < MAXT; i++) e_idx[i] = s;
      if (junk) begin d_hv[tt] = 1; d_val[tt] = 32767; d_flag[tt] = 1; end
      acc = 0;
      t = tt;
      for (int j = 0; j < cfg_size[s]; j++) begin
        t++;
        if (gaps && (j % 2 == 1)) t++;
        d_hv[t] = 1; d_val[t] = cfg_vals[s][j]; d_flag[t] = (j == cfg_fpos[s]);
        if (((j == cfg_fpos[s]) != (j == cfg_size[s] - 1)) && (t + 1 < errf)) errf = t + 1;
        acc = sat24(acc + longint'(cfg_vals[s][j]));
      end
      last = t;
      if (junk) begin d_hv[last+1] = 1; d_val[last+1] = 32767; d_flag[last+1] = 1; end
      m_last_acc = acc;
      if ((acc < longint'(cfg_thr[s])) || (s == nstage - 1)) begin
        fin = 1;
        cv = last + 2;
        newcand = (acc >= longint'(cfg_thr[s])) ? 1 : 0;
      end else begin
        s++;
        tt = last + 3;
      end
    end
    for (int i = 0; i < MAXT; i++) begin
      e_rdy[i]  = (i == 0 || i > cv) ? 1 : 0;
      e_cv[i]   = (i == cv) ? 1 : 0;
      e_cand[i] = (i >= cv) ? newcand : m_cand[k];
      e_err[i]  = (m_err[k] != 0 || i >= errf) ? 1 : 0;
    end
    m_cv = cv; m_ntrig = s + 1; m_errf = errf;
    if (abort_at > 0) begin
      d_rst[abort_at] = 0;
      for (int i = abort_at + 1; i < MAXT; i++) begin
        d_hv[i] = 0; d_win[i] = 0;
        e_rdy[i] = 1; e_trig[i] = 0; e_cv[i] = 0; e_cand[i] = 0; e_err[i] = 0; e_idx[i] = 0;
      end
      m_len = abort_at + 3;
      for (int i = 0; i < 2; i++) begin m_cand[i] = 0; m_err[i] = 0; m_idx[i] = 0; end
    end else begin
      m_len = cv + 2;
      m_cand[k] = newcand;
      if (errf < MAXT) m_err[k] = 1;
      m_idx[k] = s;
    end
  endtask

  task automatic run_window(input bit sel1);
    for (int t = 0; t < m_len; t++) begin
      @(posedge clk_fpga); #1;
      if (t == 0) begin use1 = sel1; obs_trig = 0; obs_cv = 0; end
      reset_fpga = d_rst[t];
      win1  = sel1 && d_win[t];
      win3  = !sel1 && d_win[t];
      hv    = d_hv[t];
      hval  = 16'(d_val[t]);
      hflag = d_flag[t];
      x_rdy = e_rdy[t]; x_trig = e_trig[t]; x_cv = e_cv[t];
      x_cand = e_cand[t]; x_err = e_err[t]; x_idx = e_idx[t];
    end
  endtask

  task automatic apply_reset();
    chk_en = 0;
    reset_fpga = 0; win1 = 0; win3 = 0; hv = 0; hval = '0; hflag = 0;
    repeat (2) @(posedge clk_fpga);
    #1;
    check("rst_ready1", int'(rdy1), 1);   check("rst_ready3", int'(rdy3), 1);
    check("rst_trig1", int'(trig1), 0);   check("rst_trig3", int'(trig3), 0);
    check("rst_cv1", int'(cv1), 0);       check("rst_cv3", int'(cv3), 0);
    check("rst_cand1", int'(cand1), 0);   check("rst_cand3", int'(cand3), 0);
    check("rst_err1", int'(err1), 0);     check("rst_err3", int'(err3), 0);
    check("rst_idx1", int'(idx1), 0);     check("rst_idx3", int'(idx3), 0);
    reset_fpga = 1;
    for (int i = 0; i < 2; i++) begin m_cand[i] = 0; m_err[i] = 0; m_idx[i] = 0; end
    x_rdy = 1; x_trig = 0; x_cv = 0; x_cand = 0; x_err = 0; x_idx = 0;
    chk_en = 1;
  endtask

  always @(negedge clk_fpga) begin
    if (chk_en) begin
      check("window_ready", int'(a_rdy), x_rdy);
      check("trigger", int'(a_trig), x_trig);
      check("candidate_valid", int'(a_cv), x_cv);
      check("is_candidate", int'(a_cand), x_cand);
      check("protocol_error", int'(a_err), x_err);
      check("stage_index", int'(a_idx), x_idx);
      check("idle_inst_ready", int'(o_rdy), 1);
      check("idle_inst_trigger", int'(o_trig), 0);
      check("idle_inst_cand_valid", int'(o_cv), 0);
      if (a_trig) obs_trig++;
      if (a_cv) obs_cv++;
    end
  end

  initial begin
    use1 = 1;
    for (int s = 0; s < 3; s++) set_stage(s, 0, 0, 0, -1);
    apply_reset();

    // One stage, 4+4+4 against 10: pass.
    set_stage(0, 3, 10, 4, -1);
    build_window(1, 0, 0, 0);
    check("t1_model_cv_cycle", m_cv, 7);
    check("t1_model_triggers", m_ntrig, 1);
    run_window(1);
    check("t1_triggers", obs_trig, 1);
    check("t1_cv_pulses", obs_cv, 1);
    check("t1_is_candidate", int'(cand1), 1);
    check("t1_error", int'(err1), 0);

    // Three stages, stage 0 fails; stray inputs while busy must be ignored.
    set_stage(0, 2, 5, 1, -1);
    build_window(0, 1, 0, 0);
    check("t2_model_cv_cycle", m_cv, 6);
    run_window(0);
    check("t2_triggers", obs_trig, 1);
    check("t2_is_candidate", int'(cand3), 0);

    // Three stages all pass, thresholds hit exactly, results with idle gaps.
    cfg_three_pass();
    build_window(0, 0, 1, 0);
    check("t3_model_cv_cycle", m_cv, 18);
    run_window(0);
    check("t3_triggers", obs_trig, 3);
    check("t3_is_candidate", int'(cand3), 1);
    check("t3_final_index", int'(idx3), 2);

    // Empty stage: threshold 0 passes, threshold 1 fails.
    set_stage(0, 0, 0, 0, -1);
    build_window(1, 0, 0, 0);
    check("t4_model_cv_cycle", m_cv, 4);
    run_window(1);
    check("t4_is_candidate", int'(cand1), 1);
    set_stage(0, 0, 1, 0, -1);
    build_window(1, 0, 0, 0);
    run_window(1);
    check("t5_is_candidate", int'(cand1), 0);

    // End flag on the first of three results: sticky error, decision still on all three.
    set_stage(0, 3, 3, 1, 0);
    build_window(1, 0, 0, 0);
    check("t6_model_err_cycle", m_errf, 4);
    run_window(1);
    check("t6_error", int'(err1), 1);
    check("t6_is_candidate", int'(cand1), 1);

    // Saturation both ways: wrapping would flip each decision.
    set_stage(0, NV, 32767, 32767, -1);
    build_window(1, 0, 0, 0);
    check("t7_model_acc", int'(m_last_acc), 8388607);
    run_window(1);
    check("t7_is_candidate", int'(cand1), 1);
    check("t7_error_sticky", int'(err1), 1);
    set_stage(0, NV, -32768, -32768, -1);
    build_window(1, 0, 0, 0);
    check("t8_model_acc", int'(m_last_acc), -8388608);
    run_window(1);
    check("t8_is_candidate", int'(cand1), 0);

    apply_reset();

    // Reset in the middle of accumulation: no result pulse, ready right after release.
    set_stage(0, NV, 32767, 32767, -1);
    build_window(0, 0, 0, 10);
    run_window(0);
    check("t9_cv_pulses", obs_cv, 0);
    check("t9_ready_after_abort", int'(rdy3), 1);

    // Normal operation resumes after the abort.
    cfg_three_pass();
    build_window(0, 0, 0, 0);
    run_window(0);
    check("t10_triggers", obs_trig, 3);
    check("t10_is_candidate", int'(cand3), 1);

    @(posedge clk_fpga); #1;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
